fetch_module: RTL and testbench
===============================

# fetch_module

Instruction-fetch stage of the MIPS pipeline and the producer side of the IF/ID boundary. Holds the program counter, reads a word-addressed instruction memory, and registers the fetched word and its PC+4 into the IF/ID pipeline register that the decode stage consumes. Honours stall requests from hazard detection and redirects/squashes on a taken branch resolved downstream.

## Interface

Parameters:
- `IMEM_DEPTH`, 256: instruction memory depth in 32-bit words; power of two.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; word aligned.

Ports:
- `clk`  in  1  single pipeline clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold PC and IF/ID contents this cycle.
- `flush`  in  1  load a bubble into IF/ID this cycle.
- `PCSrc`  in  1  taken branch: redirect PC to `branchTarget`.
- `branchTarget`  in  32  redirect address.
- `imemWrite`  in  1  instruction memory load strobe.
- `imemAddr`  in  32  byte address for the load port.
- `imemData`  in  32  word to store.
- `PC`  out  32  current fetch address.
- `instruction`  out  32  IF/ID instruction to decode.
- `PC_plus4`  out  32  IF/ID copy of fetch address + 4.
- `valid`  out  1  IF/ID holds a real, non-bubble instruction.

## Operation

- Memory word index = address[log2(IMEM_DEPTH)+1:2]. Upper bits ignored, so addresses wrap modulo IMEM_DEPTH words. Bits [1:0] ignored on fetch and load.
- Memory is not reset. Contents come only from the load port. A load writes on the rising edge when `imemWrite`=1.
- A fetch and a load to the same word in the same cycle: the fetch returns the old word (read-before-write).
- Each rising edge, evaluated in this priority order:
  1. `PCSrc`=1:
     - PC <= {branchTarget[31:2],2'b00}.
     - IF/ID <= bubble.
     - This takes effect regardless of `stall` or `flush`.
  2. else `stall`=1:
     - PC, instruction, PC_plus4 and valid all hold.
     - `flush` is ignored this cycle.
  3. else `flush`=1:
     - IF/ID <= bubble.
     - PC <= PC+4.
  4. else, normal fetch:
     - instruction <= mem[PC].
     - PC_plus4 <= PC+4.
     - valid <= 1.
     - PC <= PC+4.
- Bubble: instruction=32'h0000_0000 (sll $0,$0,0, a NOP), PC_plus4=0, valid=0.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 = 0.
- No internal FSM beyond the PC/IF-ID registers. The "first fetch" condition is implicit in `valid`.

## Timing

- Reset (`rst_n`=0, asynchronous assert):
  - PC=RESET_PC.
  - instruction=0.
  - PC_plus4=0.
  - valid=0.
- Deassertion is sampled at the next rising edge.
- Fetch latency is one cycle. The word at address PC in cycle n appears on `instruction` after edge n, with `PC_plus4`=PC+4.
- Steady state: one instruction per cycle. `PC` advances by 4 per unstalled edge.
- Taken branch: the target word appears on `instruction` two edges after the `PCSrc` edge:
  - the redirect edge loads a bubble;
  - the next edge fetches the target.
- Stall is level-sensitive, one cycle per asserted cycle, with no limit on length.
- Reset asserted mid-stream clears all outputs immediately. Memory contents are retained.
- Load-port write is visible to a fetch on the following cycle.

## Test plan

- **Reset and sequential fetch:** preload mem[0..3]=32'h2001_0005, 32'h2002_0007, 32'h0022_1820, 32'hAC03_0010; release reset.
  - Edge 1: instruction=32'h2001_0005, PC_plus4=4, valid=1, PC=4.
  - Edge 4: instruction=32'hAC03_0010, PC=16.
- **Stall hold:** assert `stall` for 3 cycles after edge 2.
  - instruction stays 32'h2002_0007, PC stays 8, valid stays 1.
  - After release, the next edge gives 32'h0022_1820.
- **Taken branch:** at PC=8, pulse PCSrc=1 with branchTarget=32'h0000_0041.
  - Next edge: PC=32'h40, instruction=0, valid=0.
  - Following edge: instruction=mem[16], PC_plus4=32'h44.
- **Priority:** PCSrc=1 with stall=1 and flush=1 in the same cycle → redirect and bubble taken as in the taken-branch case. Then stall=1 with flush=1 → full hold, valid unchanged.
- **Wrap and alignment:** IMEM_DEPTH=256, branchTarget=32'h0000_0400.
  - Fetch returns mem[0].
  - Separately, PC=32'hFFFF_FFFC advances to 0.
- **Async reset mid-stream and read-before-write:**
  - Drop rst_n between edges → outputs go to reset values before the next edge; memory preserved.
  - Load mem[PC] in the same cycle it is fetched → old word is fetched; the new word is seen on a refetch.

Source files
------------

// File: rtl/fetch_module.sv
// -----------------------------------------------------------------------------
// fetch_module
//
// Instruction-fetch stage of the MIPS pipeline. It owns the program counter
// and a word-addressed instruction memory. It registers the fetched word and
// PC+4 into the IF/ID pipeline register that feeds decode.
//
// Parameters
//   IMEM_DEPTH    instruction memory depth in 32-bit words (power of two)
//   RESET_PC      PC loaded on reset (word aligned)
//
// Ports
//   clk           pipeline clock, rising-edge active
//   rst_n         asynchronous active-low reset
//   stall         hold PC and IF/ID for this cycle
//   flush         load a bubble into IF/ID for this cycle (PC still advances)
//   PCSrc         taken branch: redirect PC to branchTarget and squash IF/ID
//   branchTarget  redirect byte address (bits [1:0] dropped)
//   imemWrite     instruction memory load strobe
//   imemAddr      byte address for the load port
//   imemData      word to store through the load port
//   PC            current fetch address
//   instruction   IF/ID instruction word
//   PC_plus4      IF/ID copy of fetch address + 4
//   valid         IF/ID holds a real (non-bubble) instruction
// -----------------------------------------------------------------------------
module fetch_module #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        PCSrc,
    input  logic [31:0] branchTarget,
    input  logic        imemWrite,
    input  logic [31:0] imemAddr,
    input  logic [31:0] imemData,
    output logic [31:0] PC,
    output logic [31:0] instruction,
    output logic [31:0] PC_plus4,
    output logic        valid
);

    localparam int AW = $clog2(IMEM_DEPTH);

    // The memory is deliberately left out of reset. Its contents survive a
    // mid-stream reset.
    logic [31:0]   mem [IMEM_DEPTH];
    logic [AW-1:0] fetch_idx;
    logic [AW-1:0] load_idx;
    logic [31:0]   pc_inc;

    // Word index drops the byte-offset bits. The upper bits are ignored, so
    // addresses wrap modulo the memory depth.
    assign fetch_idx = PC[AW+1:2];
    assign load_idx  = imemAddr[AW+1:2];
    assign pc_inc    = PC + 32'd4;

    // These bits do not affect behaviour. Folding them here keeps them
    // visibly accounted for.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{imemAddr[31:AW+2], imemAddr[1:0], branchTarget[1:0]};

    // Load port. Both processes sample the memory on the same edge, so a
    // fetch of the word being written returns the old contents.
    always_ff @(posedge clk) begin
        if (imemWrite) begin
            mem[load_idx] <= imemData;
        end
    end

    // ---- IF -> IF/ID boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC          <= RESET_PC;
            instruction <= 32'h0000_0000;
            PC_plus4    <= 32'h0000_0000;
            valid       <= 1'b0;
        end else if (PCSrc) begin
            // A redirect beats stall and flush. The wrong-path word is squashed.
            PC          <= {branchTarget[31:2], 2'b00};
            instruction <= 32'h0000_0000;
            PC_plus4    <= 32'h0000_0000;
            valid       <= 1'b0;
        end else if (stall) begin
            // Full hold. A concurrent flush is dropped until the stall clears.
            PC          <= PC;
            instruction <= instruction;
            PC_plus4    <= PC_plus4;
            valid       <= valid;
        end else if (flush) begin
            PC          <= pc_inc;
            instruction <= 32'h0000_0000;
            PC_plus4    <= 32'h0000_0000;
            valid       <= 1'b0;
        end else begin
            PC          <= pc_inc;
            instruction <= mem[fetch_idx];
            PC_plus4    <= pc_inc;
            valid       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_module.sv
module tb_fetch_module;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        PCSrc;
    logic [31:0] branchTarget;
    logic        imemWrite;
    logic [31:0] imemAddr;
    logic [31:0] imemData;
    logic [31:0] PC;
    logic [31:0] instruction;
    logic [31:0] PC_plus4;
    logic        valid;

    int checks = 0;
    int fails  = 0;

    // Packed view of every observable register: {PC, instruction, PC_plus4, valid}.
    logic [96:0] obs;
    assign obs = {PC, instruction, PC_plus4, valid};

    fetch_module #(
        .IMEM_DEPTH(256),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .flush       (flush),
        .PCSrc       (PCSrc),
        .branchTarget(branchTarget),
        .imemWrite   (imemWrite),
        .imemAddr    (imemAddr),
        .imemData    (imemData),
        .PC          (PC),
        .instruction (instruction),
        .PC_plus4    (PC_plus4),
        .valid       (valid)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] data);
        imemWrite = 1'b1;
        imemAddr  = addr;
        imemData  = data;
        tick();
        imemWrite = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 1'b0; flush = 1'b0; PCSrc = 1'b0;
        branchTarget = 32'h0; imemWrite = 1'b0; imemAddr = 32'h0; imemData = 32'h0;
        #2;
        load(32'h0000_0000, 32'h2001_0005);
        load(32'h0000_0004, 32'h2002_0007);
        load(32'h0000_0008, 32'h0022_1820);
        load(32'h0000_000C, 32'hAC03_0010);
        load(32'h0000_0040, 32'h1234_5678);
        load(32'h0000_03FC, 32'hDEAD_BEEF);
        checks++;
        if (obs !== {32'h0, 32'h0, 32'h0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: got %h required %h", obs, {32'h0, 32'h0, 32'h0, 1'b0});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_seq_and_stall();
        tick();
        checks++;
        if (obs !== {32'h4, 32'h2001_0005, 32'h4, 1'b1}) begin
            fails++;
            $display("FAIL seq_edge1: got %h required %h", obs, {32'h4, 32'h2001_0005, 32'h4, 1'b1});
        end
        tick();
        checks++;
        if (obs !== {32'h8, 32'h2002_0007, 32'h8, 1'b1}) begin
            fails++;
            $display("FAIL seq_edge2: got %h required %h", obs, {32'h8, 32'h2002_0007, 32'h8, 1'b1});
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== {32'h8, 32'h2002_0007, 32'h8, 1'b1}) begin
                fails++;
                $display("FAIL stall_hold_%0d: got %h required %h", i, obs, {32'h8, 32'h2002_0007, 32'h8, 1'b1});
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (obs !== {32'hC, 32'h0022_1820, 32'hC, 1'b1}) begin
            fails++;
            $display("FAIL stall_release: got %h required %h", obs, {32'hC, 32'h0022_1820, 32'hC, 1'b1});
        end
        tick();
        checks++;
        if (obs !== {32'h10, 32'hAC03_0010, 32'h10, 1'b1}) begin
            fails++;
            $display("FAIL seq_edge4: got %h required %h", obs, {32'h10, 32'hAC03_0010, 32'h10, 1'b1});
        end
    endtask

    task automatic test_branch();
        PCSrc = 1'b1; branchTarget = 32'h0000_0041;
        tick();
        PCSrc = 1'b0;
        checks++;
        if (obs !== {32'h40, 32'h0, 32'h0, 1'b0}) begin
            fails++;
            $display("FAIL branch_redirect: got %h required %h", obs, {32'h40, 32'h0, 32'h0, 1'b0});
        end
        tick();
        checks++;
        if (obs !== {32'h44, 32'h1234_5678, 32'h44, 1'b1}) begin
            fails++;
            $display("FAIL branch_target_fetch: got %h required %h", obs, {32'h44, 32'h1234_5678, 32'h44, 1'b1});
        end
    endtask

    task automatic test_priority();
        PCSrc = 1'b1; stall = 1'b1; flush = 1'b1; branchTarget = 32'h0000_0008;
        tick();
        PCSrc = 1'b0; stall = 1'b0; flush = 1'b0;
        checks++;
        if (obs !== {32'h8, 32'h0, 32'h0, 1'b0}) begin
            fails++;
            $display("FAIL prio_branch_wins: got %h required %h", obs, {32'h8, 32'h0, 32'h0, 1'b0});
        end
        tick();
        checks++;
        if (obs !== {32'hC, 32'h0022_1820, 32'hC, 1'b1}) begin
            fails++;
            $display("FAIL prio_refetch: got %h required %h", obs, {32'hC, 32'h0022_1820, 32'hC, 1'b1});
        end
        stall = 1'b1; flush = 1'b1;
        tick();
        stall = 1'b0;
        checks++;
        if (obs !== {32'hC, 32'h0022_1820, 32'hC, 1'b1}) begin
            fails++;
            $display("FAIL prio_stall_over_flush: got %h required %h", obs, {32'hC, 32'h0022_1820, 32'hC, 1'b1});
        end
        tick();
        flush = 1'b0;
        checks++;
        if (obs !== {32'h10, 32'h0, 32'h0, 1'b0}) begin
            fails++;
            $display("FAIL flush_bubble: got %h required %h", obs, {32'h10, 32'h0, 32'h0, 1'b0});
        end
    endtask

    task automatic test_wrap();
        PCSrc = 1'b1; branchTarget = 32'h0000_0400;
        tick();
        PCSrc = 1'b0;
        checks++;
        if (obs !== {32'h400, 32'h0, 32'h0, 1'b0}) begin
            fails++;
            $display("FAIL wrap_redirect: got %h required %h", obs, {32'h400, 32'h0, 32'h0, 1'b0});
        end
        tick();
        checks++;
        if (obs !== {32'h404, 32'h2001_0005, 32'h404, 1'b1}) begin
            fails++;
            $display("FAIL wrap_index: got %h required %h", obs, {32'h404, 32'h2001_0005, 32'h404, 1'b1});
        end
        PCSrc = 1'b1; branchTarget = 32'hFFFF_FFFF;
        tick();
        PCSrc = 1'b0;
        checks++;
        if (obs !== {32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0}) begin
            fails++;
            $display("FAIL top_align: got %h required %h", obs, {32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0});
        end
        tick();
        checks++;
        if (obs !== {32'h0, 32'hDEAD_BEEF, 32'h0, 1'b1}) begin
            fails++;
            $display("FAIL pc_wrap_zero: got %h required %h", obs, {32'h0, 32'hDEAD_BEEF, 32'h0, 1'b1});
        end
    endtask

    task automatic test_async_reset_and_rbw();
        tick();
        checks++;
        if (obs !== {32'h4, 32'h2001_0005, 32'h4, 1'b1}) begin
            fails++;
            $display("FAIL pre_reset_fetch: got %h required %h", obs, {32'h4, 32'h2001_0005, 32'h4, 1'b1});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== {32'h0, 32'h0, 32'h0, 1'b0}) begin
            fails++;
            $display("FAIL async_reset_clear: got %h required %h", obs, {32'h0, 32'h0, 32'h0, 1'b0});
        end
        #1 rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== {32'h4, 32'h2001_0005, 32'h4, 1'b1}) begin
            fails++;
            $display("FAIL mem_retained: got %h required %h", obs, {32'h4, 32'h2001_0005, 32'h4, 1'b1});
        end
        // Overwrite the word at PC=4 on the same edge that fetches it.
        imemWrite = 1'b1; imemAddr = 32'h0000_0004; imemData = 32'hCAFE_F00D;
        tick();
        imemWrite = 1'b0;
        checks++;
        if (obs !== {32'h8, 32'h2002_0007, 32'h8, 1'b1}) begin
            fails++;
            $display("FAIL read_before_write: got %h required %h", obs, {32'h8, 32'h2002_0007, 32'h8, 1'b1});
        end
        PCSrc = 1'b1; branchTarget = 32'h0000_0004;
        tick();
        PCSrc = 1'b0;
        tick();
        checks++;
        if (obs !== {32'h8, 32'hCAFE_F00D, 32'h8, 1'b1}) begin
            fails++;
            $display("FAIL refetch_new_word: got %h required %h", obs, {32'h8, 32'hCAFE_F00D, 32'h8, 1'b1});
        end
    endtask

    initial begin
        test_reset();
        test_seq_and_stall();
        test_branch();
        test_priority();
        test_wrap();
        test_async_reset_and_rbw();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
